instruction_fetch: RTL and testbench

Instruction fetch stage for the single-issue MIPS core. It owns the program counter and drives the word read address into the 128 x 32 instruction memory. It accepts the combinational instruction word back in the same cycle and registers it, with its PC, into the IF/ID pipeline register for decode. It also handles execute-stage redirects, decode stalls, zero-penalty `j` redirection and a halt opcode.

---
 rtl/instruction_fetch.sv | 91 +++++++++
 tb/tb_instruction_fetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads the 128-word instruction memory and
// fills the IF/ID register, with redirect, stall, zero-penalty j and halt handling.
module instruction_fetch #(
  parameter int unsigned           ADDR_W   = 7,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter logic [5:0]            HALT_OP  = 6'b111111
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] im_readAddr,
  input  logic [31:0]       instruction,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic              halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [31:0]       instr_d;
  logic [ADDR_W-1:0] if_pc_d;
  logic              valid_d;

  logic              is_j;
  logic              is_halt;
  logic [ADDR_W-1:0] j_target;
  logic              unused_bits;

  assign is_j        = (instruction[31:26] == 6'b000010);
  assign is_halt     = (instruction[31:26] == HALT_OP);
  assign j_target    = instruction[ADDR_W-1:0];
  assign unused_bits = ^instruction[25:ADDR_W];

  assign im_readAddr    = pc;
  assign halted         = (state == HALT);
  assign if_id_pc_plus1 = if_id_pc + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= RUN;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      pc          <= pc_d;
      state       <= state_d;
      if_id_instr <= instr_d;
      if_id_pc    <= if_pc_d;
      if_id_valid <= valid_d;
    end
  end

  // Priority: redirect > stall > HALT bubbles > halt word > j > sequential.
  always_comb begin
    pc_d    = pc;
    state_d = state;
    instr_d = if_id_instr;
    if_pc_d = if_id_pc;
    valid_d = if_id_valid;
    if (redirect) begin
      pc_d    = redirect_pc;
      state_d = RUN;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (state == HALT) begin
        instr_d = '0;
        valid_d = 1'b0;
      end else begin
        instr_d = instruction;
        if_pc_d = pc;
        valid_d = 1'b1;
        if (is_halt) begin
          state_d = HALT;
        end else if (is_j) begin
          pc_d = j_target;
        end else begin
          pc_d = pc + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: each queue entry carries the stimulus for
// one cycle and the IF/ID / address / halted values expected after that edge.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  im_readAddr;
  logic [31:0] instruction;
  logic        stall;
  logic        redirect;
  logic [6:0]  redirect_pc;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_pc;
  logic [6:0]  if_id_pc_plus1;
  logic        if_id_valid;
  logic        halted;

  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [6:0]  rpc;
    logic [54:0] val;
    logic [54:0] mask;
  } sb_t;

  sb_t sbq[$];

  localparam logic [54:0] FULL = '1;
  // Bubble contents leave if_id_pc unspecified, so both pc fields are ignored.
  localparam logic [54:0] BUB  = {32'hFFFF_FFFF, 14'h0, 1'b1, 7'h7F, 1'b1};

  logic [54:0] act;
  assign act = {if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid, im_readAddr, halted};

  assign instruction = mem[im_readAddr];

  instruction_fetch #(
    .ADDR_W  (7),
    .RESET_PC(7'd0),
    .HALT_OP (6'b111111)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .im_readAddr   (im_readAddr),
    .instruction   (instruction),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus1(if_id_pc_plus1),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [54:0] pk(logic [31:0] i, logic [6:0] p, logic v,
                                     logic [6:0] a, logic h);
    logic [6:0] p1;
    p1 = p + 7'd1;
    return {i, p, p1, v, a, h};
  endfunction

  task automatic push(logic s, logic r, logic [6:0] rpc, logic [54:0] val, logic [54:0] mask);
    sb_t e;
    e.stall = s; e.redir = r; e.rpc = rpc; e.val = val; e.mask = mask;
    sbq.push_back(e);
  endtask

  task automatic test_reset;
    int n = 0;
    sb_t e;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #2;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act !== pk(32'h0, 7'd0, 1'b0, 7'd0, 1'b0)) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", act, pk(32'h0, 7'd0, 1'b0, 7'd0, 1'b0));
    end
    reset = 1'b0;
    for (int k = 1; k <= 5; k++)
      push(1'b0, 1'b0, 7'd0, pk(mem[k-1], 7'(k-1), 1'b1, 7'(k), 1'b0), FULL);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      stall = e.stall; redirect = e.redir; redirect_pc = e.rpc;
      @(posedge clk); #1;
      checks++;
      if ((act & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL seq[%0d] got %h exp %h", n, act, e.val);
      end
      n++;
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_jump;
    int n = 0;
    sb_t e;
    push(1'b0, 1'b1, 7'd39, pk(32'h0, 7'd0, 1'b0, 7'd39, 1'b0), BUB);
    push(1'b0, 1'b0, 7'd0, pk(32'h0800_002B, 7'd39, 1'b1, 7'd43, 1'b0), FULL);
    push(1'b0, 1'b0, 7'd0, pk(mem[43], 7'd43, 1'b1, 7'd44, 1'b0), FULL);
    push(1'b0, 1'b0, 7'd0, pk(mem[44], 7'd44, 1'b1, 7'd45, 1'b0), FULL);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      stall = e.stall; redirect = e.redir; redirect_pc = e.rpc;
      @(posedge clk); #1;
      checks++;
      if ((act & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL jump[%0d] got %h exp %h", n, act, e.val);
      end
      n++;
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_stall_redirect;
    int n = 0;
    sb_t e;
    push(1'b0, 1'b1, 7'd35, pk(32'h0, 7'd0, 1'b0, 7'd35, 1'b0), BUB);
    push(1'b0, 1'b0, 7'd0, pk(mem[35], 7'd35, 1'b1, 7'd36, 1'b0), FULL);
    push(1'b1, 1'b0, 7'd0, pk(mem[35], 7'd35, 1'b1, 7'd36, 1'b0), FULL);
    push(1'b1, 1'b1, 7'd40, pk(32'h0, 7'd0, 1'b0, 7'd40, 1'b0), BUB);
    push(1'b1, 1'b0, 7'd0, pk(32'h0, 7'd0, 1'b0, 7'd40, 1'b0), BUB);
    push(1'b0, 1'b0, 7'd0, pk(mem[40], 7'd40, 1'b1, 7'd41, 1'b0), FULL);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      stall = e.stall; redirect = e.redir; redirect_pc = e.rpc;
      @(posedge clk); #1;
      checks++;
      if ((act & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL stall_redir[%0d] got %h exp %h", n, act, e.val);
      end
      n++;
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_wrap;
    int n = 0;
    sb_t e;
    push(1'b0, 1'b1, 7'd127, pk(32'h0, 7'd0, 1'b0, 7'd127, 1'b0), BUB);
    push(1'b0, 1'b0, 7'd0, pk(mem[127], 7'd127, 1'b1, 7'd0, 1'b0), FULL);
    push(1'b0, 1'b0, 7'd0, pk(mem[0], 7'd0, 1'b1, 7'd1, 1'b0), FULL);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      stall = e.stall; redirect = e.redir; redirect_pc = e.rpc;
      @(posedge clk); #1;
      checks++;
      if ((act & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL wrap[%0d] got %h exp %h", n, act, e.val);
      end
      n++;
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_halt;
    int n = 0;
    sb_t e;
    push(1'b0, 1'b1, 7'd4, pk(32'h0, 7'd0, 1'b0, 7'd4, 1'b0), BUB);
    push(1'b0, 1'b0, 7'd0, pk(mem[4], 7'd4, 1'b1, 7'd5, 1'b0), FULL);
    push(1'b0, 1'b0, 7'd0, pk(32'hFC00_0000, 7'd5, 1'b1, 7'd5, 1'b1), FULL);
    for (int k = 0; k < 10; k++)
      push(1'b0, 1'b0, 7'd0, pk(32'h0, 7'd0, 1'b0, 7'd5, 1'b1), BUB);
    push(1'b0, 1'b1, 7'd0, pk(32'h0, 7'd0, 1'b0, 7'd0, 1'b0), BUB);
    push(1'b0, 1'b0, 7'd0, pk(mem[0], 7'd0, 1'b1, 7'd1, 1'b0), FULL);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      stall = e.stall; redirect = e.redir; redirect_pc = e.rpc;
      @(posedge clk); #1;
      checks++;
      if ((act & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL halt[%0d] got %h exp %h", n, act, e.val);
      end
      n++;
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_async_reset;
    int n = 0;
    sb_t e;
    redirect = 1'b1; redirect_pc = 7'd39;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++;
    if (act !== pk(32'h0, 7'd0, 1'b0, 7'd0, 1'b0)) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", act, pk(32'h0, 7'd0, 1'b0, 7'd0, 1'b0));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    push(1'b0, 1'b0, 7'd0, pk(mem[0], 7'd0, 1'b1, 7'd1, 1'b0), FULL);
    push(1'b0, 1'b0, 7'd0, pk(mem[1], 7'd1, 1'b1, 7'd2, 1'b0), FULL);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      stall = e.stall; redirect = e.redir; redirect_pc = e.rpc;
      @(posedge clk); #1;
      checks++;
      if ((act & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL post_reset[%0d] got %h exp %h", n, act, e.val);
      end
      n++;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h2100_0000 + i;
    mem[0]  = 32'h2010_0007;
    mem[5]  = 32'hFC00_0000;
    mem[39] = 32'h0800_002B;
    test_reset();
    test_jump();
    test_stall_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
